// File: rtl/drive_pkg.sv
// Shared command and state encodings for the drive command path.
// Contents:
//   CMD_STOP/CMD_FWD/CMD_LEFT/CMD_RIGHT  2-bit motor command codes
//   state_e                              FSM states ST_IDLE/ST_MANUAL/ST_AUTO/ST_HALT
package drive_pkg;

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b01;
    localparam logic [1:0] CMD_LEFT  = 2'b10;
    localparam logic [1:0] CMD_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10,
        ST_HALT   = 2'b11
    } state_e;

endpackage

// File: rtl/drive_deadtime.sv
// Direction-change dead-time stage: registers the effective motor command and inserts
// DEAD_CYCLES cycles of stop between two different non-stop commands.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   en      in   1 = command path active; 0 forces stop and aborts any dead time
//   eff     in   effective (already obstacle-masked) command
//   driver  out  registered motor command
// Only instantiated when DRIVE_DEADTIME_EN is defined.
module drive_deadtime
    import drive_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] eff,
    output logic [1:0] driver
);

    localparam int unsigned DW = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

    logic [1:0]    driver_q, driver_d;
    logic [1:0]    tgt_q, tgt_d;      // command waiting for the dead time to expire
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;  // nonzero = dead time in progress

    always_comb begin
        driver_d   = driver_q;
        tgt_d      = tgt_q;
        dead_cnt_d = dead_cnt_q;
        if (!en || eff == CMD_STOP) begin
            // Stop always wins immediately and cancels a pending change.
            driver_d   = CMD_STOP;
            dead_cnt_d = '0;
        end else if (dead_cnt_q != '0) begin
            if (eff != tgt_q) begin
                tgt_d      = eff;
                dead_cnt_d = DEAD_LOAD;
            end else if (dead_cnt_q == DW'(1)) begin
                driver_d   = tgt_q;
                dead_cnt_d = '0;
            end else begin
                dead_cnt_d = dead_cnt_q - 1'b1;
            end
        end else if (driver_q == CMD_STOP || eff == driver_q) begin
            driver_d = eff;
        end else begin
            // Reversal between two non-stop commands: coast first.
            driver_d   = CMD_STOP;
            tgt_d      = eff;
            dead_cnt_d = DEAD_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            driver_q   <= CMD_STOP;
            tgt_q      <= CMD_STOP;
            dead_cnt_q <= '0;
        end else begin
            driver_q   <= driver_d;
            tgt_q      <= tgt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign driver = driver_q;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Motor-command arbiter: selects between the Bluetooth UART decoder and the autonomous
// line tracker, and applies the link watchdog, obstacle inhibit, remote kill and
// (optionally) direction-change dead time before the motor driver.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   bt_valid, bt_cmd      1-cycle pulse + command from the UART decoder
//   auto_valid, auto_cmd  1-cycle pulse + command from the line tracker
//   mode_auto             level, autonomous mode requested
//   obstacle              level, obstacle ahead (blocks forward only)
//   driver                registered motor command
//   state_o               current FSM state
//   wdt_trip              sticky watchdog flag, cleared on HALT exit
// Configuration: define DRIVE_DEADTIME_EN to enable dead-time insertion; otherwise the
// output is a plain register and DEAD_CYCLES is unused.
module drive_cmd_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned WDT_CYCLES  = 50_000_000,
    parameter int unsigned DEAD_CYCLES = 500_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_valid,
    input  logic [1:0] bt_cmd,
    input  logic       auto_valid,
    input  logic [1:0] auto_cmd,
    input  logic       mode_auto,
    input  logic       obstacle,
    output logic [1:0] driver,
    output logic [1:0] state_o,
    output logic       wdt_trip
);

    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

    state_e             state_q;
    logic [1:0]         cmd_req_q;
    logic [CNT_W-1:0]   wdt_cnt_q;
    logic               wdt_trip_q;
    logic               out_en;
    logic [1:0]         eff;
    logic [1:0]         drive_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_req_q  <= CMD_STOP;
            wdt_cnt_q  <= '0;
            wdt_trip_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wdt_cnt_q <= '0;
                    if (mode_auto) begin
                        state_q <= ST_AUTO;
                    end else if (bt_valid) begin
                        state_q   <= ST_MANUAL;
                        cmd_req_q <= bt_cmd;
                    end
                end
                ST_MANUAL: begin
                    if (mode_auto) begin
                        state_q   <= ST_AUTO;
                        cmd_req_q <= CMD_STOP;
                        wdt_cnt_q <= '0;
                    end else if (bt_valid) begin
                        cmd_req_q <= bt_cmd;
                        wdt_cnt_q <= '0;
                    end else if (wdt_cnt_q == WDT_LAST) begin
                        // Link lost. The request is dropped so no stale command can
                        // resurface after recovery.
                        state_q    <= ST_HALT;
                        wdt_trip_q <= 1'b1;
                        cmd_req_q  <= CMD_STOP;
                        wdt_cnt_q  <= '0;
                    end else begin
                        wdt_cnt_q <= wdt_cnt_q + 1'b1;
                    end
                end
                ST_AUTO: begin
                    wdt_cnt_q <= '0;
                    if (bt_valid && bt_cmd == CMD_STOP) begin
                        // Remote kill beats any tracker update in the same cycle.
                        state_q   <= ST_HALT;
                        cmd_req_q <= CMD_STOP;
                    end else if (!mode_auto) begin
                        state_q   <= ST_IDLE;
                        cmd_req_q <= CMD_STOP;
                    end else if (auto_valid) begin
                        cmd_req_q <= auto_cmd;
                    end
                end
                ST_HALT: begin
                    wdt_cnt_q <= '0;
                    if (bt_valid && bt_cmd == CMD_STOP) begin
                        state_q    <= ST_IDLE;
                        wdt_trip_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Output stage follows the registered state, so leaving MANUAL/AUTO stops the
    // motors on the following cycle.
    assign out_en = (state_q == ST_MANUAL) || (state_q == ST_AUTO);
    assign eff    = (obstacle && cmd_req_q == CMD_FWD) ? CMD_STOP : cmd_req_q;

`ifdef DRIVE_DEADTIME_EN
    drive_deadtime #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_deadtime (
        .clk    (clk),
        .rst    (rst),
        .en     (out_en),
        .eff    (eff),
        .driver (drive_out)
    );
`else
    logic [1:0] drive_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q <= CMD_STOP;
        end else begin
            drive_q <= out_en ? eff : CMD_STOP;
        end
    end

    assign drive_out = drive_q;
`endif

    assign driver   = drive_out;
    assign state_o  = state_q;
    assign wdt_trip = wdt_trip_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter: directed scenarios plus randomized traffic, every cycle
// scored against a timestamp-based reference model through a queue.
module tb_drive_cmd_arbiter;
    import drive_pkg::*;

    localparam int unsigned WDT  = 100;
    localparam int unsigned DEAD = 4;
`ifdef DRIVE_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bt_valid = 1'b0;
    logic [1:0] bt_cmd = 2'b00;
    logic       auto_valid = 1'b0;
    logic [1:0] auto_cmd = 2'b00;
    logic       mode_auto = 1'b0;
    logic       obstacle = 1'b0;
    logic [1:0] driver;
    logic [1:0] state_o;
    logic       wdt_trip;

    always #5 clk = ~clk;

    drive_cmd_arbiter #(
        .WDT_CYCLES  (WDT),
        .DEAD_CYCLES (DEAD),
        .CNT_W       (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bt_valid   (bt_valid),
        .bt_cmd     (bt_cmd),
        .auto_valid (auto_valid),
        .auto_cmd   (auto_cmd),
        .mode_auto  (mode_auto),
        .obstacle   (obstacle),
        .driver     (driver),
        .state_o    (state_o),
        .wdt_trip   (wdt_trip)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] drv;
        logic       trip;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode, request, and timestamps instead of counters.
    int cyc = 0;
    int m_st = 0;       // 0 idle, 1 manual, 2 auto, 3 halt
    int m_req = 0;
    int m_drv = 0;
    bit m_trip = 1'b0;
    int last_act = 0;   // cycle of MANUAL entry or last bt command
    bit pend = 1'b0;
    int pend_tgt = 0;
    int pend_end = 0;   // cycle at which the pending command reaches the motor

    task automatic model_step();
        int   eff;
        bit   run;
        obs_t e;
        cyc++;
        if (rst) begin
            m_st = 0; m_req = 0; m_drv = 0; m_trip = 1'b0; pend = 1'b0;
        end else begin
            run = (m_st == 1) || (m_st == 2);
            eff = (obstacle && m_req == 1) ? 0 : m_req;
            if (!DT_EN) begin
                m_drv = run ? eff : 0;
            end else if (!run || eff == 0) begin
                m_drv = 0; pend = 1'b0;
            end else if (pend) begin
                if (eff != pend_tgt) begin
                    pend_tgt = eff; pend_end = cyc + DEAD;
                end else if (cyc == pend_end) begin
                    m_drv = pend_tgt; pend = 1'b0;
                end
            end else if (m_drv == 0 || m_drv == eff) begin
                m_drv = eff;
            end else begin
                m_drv = 0; pend = 1'b1; pend_tgt = eff; pend_end = cyc + DEAD;
            end
            case (m_st)
                0: if (mode_auto) m_st = 2;
                   else if (bt_valid) begin m_st = 1; m_req = bt_cmd; last_act = cyc; end
                1: if (mode_auto) begin m_st = 2; m_req = 0; end
                   else if (bt_valid) begin m_req = bt_cmd; last_act = cyc; end
                   else if (cyc - last_act == WDT) begin m_st = 3; m_trip = 1'b1; m_req = 0; end
                2: if (bt_valid && bt_cmd == 2'b00) begin m_st = 3; m_req = 0; end
                   else if (!mode_auto) begin m_st = 0; m_req = 0; end
                   else if (auto_valid) m_req = auto_cmd;
                default: if (bt_valid && bt_cmd == 2'b00) begin m_st = 0; m_trip = 1'b0; end
            endcase
        end
        e.st = 2'(m_st); e.drv = 2'(m_drv); e.trip = m_trip;
        sb.push_back(e);
    endtask

    // One clock: inputs are held across the edge, model advances, pulses drop.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bt_valid = 1'b0;
        auto_valid = 1'b0;
    endtask

    task automatic bt(input logic [1:0] c);
        bt_valid = 1'b1; bt_cmd = c; tick();
    endtask

    task automatic au(input logic [1:0] c);
        auto_valid = 1'b1; auto_cmd = c; tick();
    endtask

    task automatic expect_now(input string name, input int st, input int drv, input bit tr);
        checks++;
        if (state_o !== 2'(st) || driver !== 2'(drv) || wdt_trip !== tr) begin
            failures++;
            $display("FAIL %s: got state=%0d driver=%0d wdt_trip=%0d, want state=%0d driver=%0d wdt_trip=%0d",
                     name, state_o, driver, wdt_trip, st, drv, tr);
        end
    endtask

    // Monitor: DUT outputs are scored on the falling edge after each update.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                obs_t e;
                e = sb.pop_front();
                checks++;
                if ({state_o, driver, wdt_trip} !== e) begin
                    failures++;
                    $display("FAIL scoreboard cyc=%0d: got state=%0d driver=%0d wdt_trip=%0d, want state=%0d driver=%0d wdt_trip=%0d",
                             cyc, state_o, driver, wdt_trip, e.st, e.drv, e.trip);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        // 1: reset, manual entry, two-cycle latency
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        expect_now("reset", 0, 0, 0);
        bt(2'b01);
        expect_now("t1_manual", 1, 0, 0);
        tick();
        expect_now("t1_drv", 1, 1, 0);
        // 2: watchdog
        repeat (98) tick();
        expect_now("t2_before_trip", 1, 1, 0);
        tick();
        expect_now("t2_trip", 3, 1, 1);
        tick();
        expect_now("t2_halt_stop", 3, 0, 1);
        bt(2'b01);
        expect_now("t2_halt_ignores_fwd", 3, 0, 1);
        bt(2'b00);
        expect_now("t2_halt_exit", 0, 0, 0);
        // 3: dead time and restart
        bt(2'b10); tick();
        expect_now("t3_left", 1, 2, 0);
        bt(2'b11); tick();
        expect_now("t3_dead_first", 1, DT_EN ? 0 : 3, 0);
        repeat (3) tick();
        expect_now("t3_dead_last", 1, DT_EN ? 0 : 3, 0);
        tick();
        expect_now("t3_right", 1, 3, 0);
        bt(2'b10); tick();
        expect_now("t3b_dead", 1, DT_EN ? 0 : 2, 0);
        bt(2'b01); tick();
        tick(); tick();
        expect_now("t3b_restart", 1, DT_EN ? 0 : 1, 0);
        tick(); tick();
        expect_now("t3b_fwd", 1, 1, 0);
        // 4: auto mode with obstacle
        mode_auto = 1'b1; tick(); tick();
        expect_now("t4_auto", 2, 0, 0);
        obstacle = 1'b1;
        au(2'b01); tick();
        expect_now("t4_fwd_blocked", 2, 0, 0);
        au(2'b10); tick();
        expect_now("t4_left_passes", 2, 2, 0);
        au(2'b01); tick();
        expect_now("t4_fwd_blocked2", 2, 0, 0);
        obstacle = 1'b0; tick();
        expect_now("t4_fwd_clear", 2, 1, 0);
        // 5: remote kill beats auto_valid; non-stop bt ignored in AUTO
        auto_valid = 1'b1; auto_cmd = 2'b01; bt(2'b00);
        expect_now("t5_kill", 3, 1, 0);
        tick();
        expect_now("t5_kill_stop", 3, 0, 0);
        bt(2'b00);
        expect_now("t5_unhalt", 0, 0, 0);
        tick();
        expect_now("t5_reauto", 2, 0, 0);
        au(2'b10); tick();
        bt(2'b11); tick();
        expect_now("t5_bt_ignored", 2, 2, 0);
        // 6: reset mid dead time and mid watchdog count
        mode_auto = 1'b0; tick();
        bt(2'b10); tick();
        bt(2'b01); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        expect_now("t6_rst_dead", 0, 0, 0);
        bt(2'b01); tick();
        expect_now("t6_no_residual_dead", 1, 1, 0);
        repeat (50) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        expect_now("t6_rst_wdt", 0, 0, 0);
        bt(2'b01);
        repeat (99) tick();
        expect_now("t6_wdt_fresh", 1, 1, 0);
        tick();
        expect_now("t6_wdt_trip", 3, 1, 1);
        bt(2'b00);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int pbt;
            pbt = ((i / 500) % 2 == 1) ? 60 : 6;
            bt_valid   = ($urandom_range(pbt - 1) == 0);
            bt_cmd     = 2'($urandom_range(3));
            auto_valid = ($urandom_range(3) == 0);
            auto_cmd   = 2'($urandom_range(3));
            if ($urandom_range(80) == 0) mode_auto = ~mode_auto;
            if ($urandom_range(10) == 0) obstacle = 1'($urandom_range(1));
            rst = ($urandom_range(700) == 0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
